// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//
// Purpose:
//   Watches a free-running 4-bit ripple counter whose value arrives asynchronously
//   and may glitch while its bits ripple. The value is double-synchronised, then
//   compared against a one-sample history so that only stable samples are used.
//   Each stable change extends the count with an 8-bit wrap counter. The result
//   is presented as a single-entry record behind a valid/ready handshake.
//
// Ports:
//   clock_n     in   1   sole clock; all state updates on its falling edge
//   reset       in   1   synchronous, active-high reset
//   cnt_in      in   4   raw ripple-counter value (asynchronous, may glitch)
//   out_ready   in   1   consumer accepts the current record
//   out_valid   out  1   count_out holds an unconsumed record
//   count_out   out  12  {wrap count[7:0], counter value[3:0]}
//   wrap_pulse  out  1   one-cycle pulse per detected backwards step (wrap)
//   skip_err    out  1   sticky: an accepted change advanced by more than 1 (mod 16)
//   overrun     out  1   sticky: a pending record was overwritten before acceptance

module ripple_count_monitor (
    input  logic        clock_n,
    input  logic        reset,
    input  logic [3:0]  cnt_in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [11:0] count_out,
    output logic        wrap_pulse,
    output logic        skip_err,
    output logic        overrun
);

    typedef enum logic [0:0] {
        StInit  = 1'b0,
        StTrack = 1'b1
    } state_e;

    // Synchroniser and history registers
    logic [3:0]  r_s1;
    logic [3:0]  r_s2;
    logic [3:0]  r_s3;

    // Counts falling edges since reset release, saturating at 3. Reset clears the
    // sync chain to zero, so the zeros left in s2/s3 must not be mistaken for a
    // real stable sample; s2/s3 only hold post-reset input once this reaches 3.
    logic [1:0]  r_fill;

    state_e      r_state;
    logic [3:0]  r_cur;
    logic [7:0]  r_wrap;
    logic        r_valid;
    logic [11:0] r_count;
    logic        r_pulse;
    logic        r_skip;
    logic        r_overrun;

    // Next-state signals
    state_e      w_state_d;
    logic [3:0]  w_cur_d;
    logic [7:0]  w_wrap_d;
    logic        w_valid_d;
    logic [11:0] w_count_d;
    logic        w_pulse_d;
    logic        w_skip_d;
    logic        w_overrun_d;
    logic [1:0]  w_fill_d;

    // Decode
    logic        w_fill_done;
    logic        w_stable;
    logic        w_accept;
    logic [3:0]  w_delta;

    assign w_fill_done = (r_fill == 2'd3);
    assign w_stable    = w_fill_done && (r_s2 == r_s3);
    // 4-bit subtraction wraps naturally, giving the forward distance mod 16
    assign w_delta     = r_s2 - r_cur;
    assign w_fill_d    = w_fill_done ? r_fill : r_fill + 2'd1;

    always_comb begin
        w_state_d   = r_state;
        w_cur_d     = r_cur;
        w_wrap_d    = r_wrap;
        w_valid_d   = r_valid;
        w_count_d   = r_count;
        w_pulse_d   = 1'b0;
        w_skip_d    = r_skip;
        w_overrun_d = r_overrun;
        w_accept    = 1'b0;

        case (r_state)
            StInit: begin
                // First stable sample only establishes the reference value
                if (w_stable) begin
                    w_cur_d   = r_s2;
                    w_state_d = StTrack;
                end
            end
            StTrack: begin
                w_accept = w_stable && (r_s2 != r_cur);
            end
            default: begin
                w_state_d = StInit;
            end
        endcase

        if (w_accept) begin
            w_cur_d = r_s2;
            if (r_s2 < r_cur) begin
                w_wrap_d  = r_wrap + 8'd1;  // rolls 255 -> 0 silently
                w_pulse_d = 1'b1;
            end
            if (w_delta > 4'd1) begin
                w_skip_d = 1'b1;
            end
            // Same-edge transfer plus new record is not an overrun
            if (r_valid && !out_ready) begin
                w_overrun_d = 1'b1;
            end
            w_count_d = {w_wrap_d, r_s2};
            w_valid_d = 1'b1;
        end else if (r_valid && out_ready) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(negedge clock_n) begin
        if (reset) begin
            r_s1      <= 4'd0;
            r_s2      <= 4'd0;
            r_s3      <= 4'd0;
            r_fill    <= 2'd0;
            r_state   <= StInit;
            r_cur     <= 4'd0;
            r_wrap    <= 8'd0;
            r_valid   <= 1'b0;
            r_count   <= 12'd0;
            r_pulse   <= 1'b0;
            r_skip    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_s1      <= cnt_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_fill    <= w_fill_d;
            r_state   <= w_state_d;
            r_cur     <= w_cur_d;
            r_wrap    <= w_wrap_d;
            r_valid   <= w_valid_d;
            r_count   <= w_count_d;
            r_pulse   <= w_pulse_d;
            r_skip    <= w_skip_d;
            r_overrun <= w_overrun_d;
        end
    end

    assign out_valid  = r_valid;
    assign count_out  = r_count;
    assign wrap_pulse = r_pulse;
    assign skip_err   = r_skip;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Self-checking bench for ripple_count_monitor: directed scenarios followed by a
// randomized run, every cycle compared against a history-based reference model.

module tb_ripple_count_monitor;

    logic        clock_n;
    logic        reset;
    logic [3:0]  cnt_in;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] count_out;
    logic        wrap_pulse;
    logic        skip_err;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    // Observation counters used by scenario checks
    int pulse_seen = 0;
    int valid_seen = 0;

    // Reference model state
    logic [3:0]  m_hist[$];   // cnt_in value sampled at each falling edge since reset
    bit          m_track;
    logic [3:0]  m_cur;
    int          m_wrap;
    logic        m_valid;
    logic [11:0] m_count;
    logic        m_pulse;
    logic        m_skip;
    logic        m_overrun;

    ripple_count_monitor u_dut (
        .clock_n    (clock_n),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .count_out  (count_out),
        .wrap_pulse (wrap_pulse),
        .skip_err   (skip_err),
        .overrun    (overrun)
    );

    initial begin
        clock_n = 1'b1;
        forever #5 clock_n = ~clock_n;
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
        end
    endtask

    // Model of one falling edge. A stable sample at edge n is two synchronised
    // samples in a row agreeing: the inputs captured at edges n-2 and n-3.
    task automatic model_edge(input logic r, input logic [3:0] c, input logic rdy);
        int         n;
        logic [3:0] a;
        logic [3:0] b;
        bit         accepted;
        if (r) begin
            m_hist.delete();
            m_track   = 0;
            m_cur     = 4'd0;
            m_wrap    = 0;
            m_valid   = 1'b0;
            m_count   = 12'd0;
            m_pulse   = 1'b0;
            m_skip    = 1'b0;
            m_overrun = 1'b0;
            return;
        end
        n        = m_hist.size();
        m_pulse  = 1'b0;
        accepted = 0;
        if (n >= 3) begin
            a = m_hist[n-2];
            b = m_hist[n-3];
            if (a == b) begin
                if (!m_track) begin
                    m_track = 1;
                    m_cur   = a;
                end else if (a != m_cur) begin
                    accepted = 1;
                    if (int'(a) < int'(m_cur)) begin
                        m_wrap  = (m_wrap + 1) % 256;
                        m_pulse = 1'b1;
                    end
                    if (((int'(a) - int'(m_cur) + 16) % 16) > 1) m_skip = 1'b1;
                    if (m_valid && !rdy) m_overrun = 1'b1;
                    m_count = 12'((m_wrap * 16) + int'(a));
                    m_valid = 1'b1;
                    m_cur   = a;
                end
            end
        end
        if (!accepted && m_valid && rdy) m_valid = 1'b0;
        m_hist.push_back(c);
    endtask

    // Drive inputs (away from the active edge), let one falling edge happen,
    // then compare every output against the model.
    task automatic tick(input logic r, input logic [3:0] c, input logic rdy);
        reset     = r;
        cnt_in    = c;
        out_ready = rdy;
        @(negedge clock_n);
        model_edge(r, c, rdy);
        #1;
        check("out_valid", 12'(out_valid), 12'(m_valid));
        check("count_out", count_out, m_count);
        check("wrap_pulse", 12'(wrap_pulse), 12'(m_pulse));
        check("skip_err", 12'(skip_err), 12'(m_skip));
        check("overrun", 12'(overrun), 12'(m_overrun));
        if (wrap_pulse === 1'b1) pulse_seen++;
        if (out_valid === 1'b1) valid_seen++;
        @(posedge clock_n);
    endtask

    task automatic hold(input logic [3:0] c, input logic rdy, input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, c, rdy);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b1, 4'($urandom_range(0, 15)), 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        cnt_in    = 4'd0;
        out_ready = 1'b0;

        // Reset state
        do_reset(3);
        check("rst_valid", 12'(out_valid), 12'd0);
        check("rst_count", count_out, 12'h000);
        check("rst_flags", {9'd0, wrap_pulse, skip_err, overrun}, 12'd0);

        // Held value after reset only establishes the reference, no record
        hold(4'd5, 1'b1, 8);
        check("init_no_valid", 12'(out_valid), 12'd0);
        check("init_count", count_out, 12'h000);
        // Latency: new value at E0 appears after E0+3
        tick(1'b0, 4'd6, 1'b1);
        check("lat_e0", 12'(out_valid), 12'd0);
        tick(1'b0, 4'd6, 1'b1);
        check("lat_e1", 12'(out_valid), 12'd0);
        tick(1'b0, 4'd6, 1'b1);
        check("lat_e2", 12'(out_valid), 12'd0);
        tick(1'b0, 4'd6, 1'b1);
        check("lat_e3_valid", 12'(out_valid), 12'd1);
        check("lat_e3_count", count_out, 12'h006);
        tick(1'b0, 4'd6, 1'b1);
        check("xfer_drop", 12'(out_valid), 12'd0);
        check("xfer_hold", count_out, 12'h006);

        // 14 -> 15 -> 0 wrap
        do_reset(1);
        hold(4'd14, 1'b1, 6);
        pulse_seen = 0;
        hold(4'd15, 1'b1, 6);
        check("wrap_rec15", count_out, 12'h00F);
        hold(4'd0, 1'b1, 6);
        check("wrap_rec0", count_out, 12'h010);
        check("wrap_pulses", 12'(pulse_seen), 12'd1);
        check("wrap_noskip", 12'(skip_err), 12'd0);

        // Glitching ripple 7 -> 6 -> 4 -> 8 settles to a single record
        do_reset(1);
        hold(4'd7, 1'b1, 6);
        valid_seen = 0;
        tick(1'b0, 4'd6, 1'b1);
        tick(1'b0, 4'd4, 1'b1);
        tick(1'b0, 4'd8, 1'b1);
        hold(4'd8, 1'b1, 6);
        check("glitch_records", 12'(valid_seen), 12'd1);
        check("glitch_count", count_out, 12'h008);
        check("glitch_noskip", 12'(skip_err), 12'd0);

        // Overrun with consumer stalled
        do_reset(1);
        hold(4'd3, 1'b0, 6);
        hold(4'd4, 1'b0, 6);
        check("ovr_first", count_out, 12'h004);
        check("ovr_none_yet", 12'(overrun), 12'd0);
        hold(4'd5, 1'b0, 6);
        check("ovr_count", count_out, 12'h005);
        check("ovr_valid", 12'(out_valid), 12'd1);
        check("ovr_flag", 12'(overrun), 12'd1);
        tick(1'b0, 4'd5, 1'b1);
        check("ovr_drain", 12'(out_valid), 12'd0);
        check("ovr_sticky", 12'(overrun), 12'd1);

        // Skip 2 -> 6 is sticky
        do_reset(1);
        hold(4'd2, 1'b1, 6);
        hold(4'd6, 1'b1, 6);
        check("skip_count", count_out, 12'h006);
        check("skip_flag", 12'(skip_err), 12'd1);
        hold(4'd7, 1'b1, 6);
        hold(4'd8, 1'b1, 6);
        check("skip_sticky", 12'(skip_err), 12'd1);
        check("skip_later", count_out, 12'h008);

        // Reset with a pending record, then 256 wraps
        hold(4'd9, 1'b0, 6);
        check("pend_valid", 12'(out_valid), 12'd1);
        tick(1'b1, 4'd9, 1'b0);
        check("mid_rst_valid", 12'(out_valid), 12'd0);
        check("mid_rst_count", count_out, 12'h000);
        check("mid_rst_flags", {9'd0, wrap_pulse, skip_err, overrun}, 12'd0);
        hold(4'd0, 1'b1, 6);
        pulse_seen = 0;
        for (int w = 0; w < 256; w++) begin
            for (int v = 1; v <= 16; v++) hold(4'(v % 16), 1'b1, 4);
            if (w == 254) check("wrap255", 12'(count_out[11:4]), 12'h0FF);
        end
        check("wrap256_hi", 12'(count_out[11:4]), 12'h000);
        check("wrap256_all", count_out, 12'h000);
        check("wrap256_pulses", 12'(pulse_seen), 12'd256);
        check("wrap256_skip", 12'(skip_err), 12'd0);
        check("wrap256_ovr", 12'(overrun), 12'd0);

        // Randomized: ragged hold times, random ready, occasional reset
        do_reset(2);
        for (int s = 0; s < 200; s++) begin
            logic [3:0] v;
            int         len;
            v   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                tick(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, v,
                     1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
